// File: rtl/count_lead_unit_pkg.sv
// Shared encodings for the leading-zero/leading-one counter.
// Operation select codes and FSM state encodings.
package count_lead_unit_pkg;

  localparam logic CNTOp_CLZ = 1'b0;
  localparam logic CNTOp_CLO = 1'b1;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_SCAN = 2'd1,
    CNT_FIN  = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/count_lead_unit_stage.sv
// One binary-search stage: when the top w bits of x are all zero,
// shift x and its shadow s left by w and report w as the count increment.
module clz_stage #(
  parameter int WIDTH = 32,
  parameter int LOGW  = 5
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] s,
  input  logic [LOGW-1:0]  k,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] s_nxt,
  output logic [LOGW:0]    inc
);

  localparam logic [LOGW:0] WFULL = (LOGW+1)'(WIDTH);

  logic [LOGW:0]    w;
  logic [WIDTH-1:0] top_mask;
  logic             hit;

  // Stage k inspects a field of width WIDTH >> (k+1) at the top of x.
  always_comb begin
    w        = WFULL >> ({1'b0, k} + (LOGW+1)'(1));
    top_mask = ~({WIDTH{1'b1}} >> w);
    hit      = ((x & top_mask) == '0);
    x_nxt    = hit ? (x << w) : x;
    s_nxt    = hit ? (s << w) : s;
    inc      = hit ? w : '0;
  end

endmodule

// File: rtl/count_lead_unit.sv
// Iterative CLZ/CLO unit: one binary-search stage per clock, then a final
// single-bit fix-up, with a Start/Done handshake towards the control FSM.
module count_lead_unit
  import count_lead_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic             CNTOp,
  output logic             Busy,
  output logic             Done,
  output logic [LOGW:0]    Count,
  output logic [WIDTH-1:0] Norm,
  output cnt_state_t       dbg_state
);

  // Handshake: Start is honoured only in CNT_IDLE (A/CNTOp captured on that
  // edge); Done pulses for one cycle when Count/Norm are updated, and a Start
  // in that same cycle is accepted with no bubble.

  cnt_state_t       state, state_nxt;
  logic [LOGW-1:0]  k, k_nxt;
  logic [WIDTH-1:0] x, x_nxt;
  logic [WIDTH-1:0] s, s_nxt;
  logic [LOGW:0]    cnt, cnt_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [LOGW:0]    count_q, count_nxt;
  logic [WIDTH-1:0] norm_q, norm_nxt;

  logic [WIDTH-1:0] stg_x, stg_s;
  logic [LOGW:0]    stg_inc;

  clz_stage #(.WIDTH(WIDTH), .LOGW(LOGW)) u_stage (
    .x     (x),
    .s     (s),
    .k     (k),
    .x_nxt (stg_x),
    .s_nxt (stg_s),
    .inc   (stg_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CNT_IDLE;
      k       <= '0;
      x       <= '0;
      s       <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      norm_q  <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      x       <= x_nxt;
      s       <= s_nxt;
      cnt     <= cnt_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      count_q <= count_nxt;
      norm_q  <= norm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    x_nxt     = x;
    s_nxt     = s;
    cnt_nxt   = cnt;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    count_nxt = count_q;
    norm_nxt  = norm_q;
    case (state)
      CNT_IDLE: begin
        if (Start) begin
          // Search runs on the conditioned value; Norm shadows the raw A.
          x_nxt     = (CNTOp == CNTOp_CLO) ? ~A : A;
          s_nxt     = A;
          cnt_nxt   = '0;
          k_nxt     = '0;
          busy_nxt  = 1'b1;
          state_nxt = CNT_SCAN;
        end
      end
      CNT_SCAN: begin
        x_nxt   = stg_x;
        s_nxt   = stg_s;
        cnt_nxt = cnt + stg_inc;
        k_nxt   = k + LOGW'(1);
        if (k == LOGW'(LOGW-1)) state_nxt = CNT_FIN;
      end
      CNT_FIN: begin
        // A zero MSB here means the conditioned operand was all zeros.
        if (!x[WIDTH-1]) begin
          cnt_nxt = cnt + (LOGW+1)'(1);
          s_nxt   = '0;
        end
        count_nxt = cnt_nxt;
        norm_nxt  = s_nxt;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = CNT_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = CNT_IDLE;
      end
    endcase
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Count     = count_q;
  assign Norm      = norm_q;
  assign dbg_state = state;

endmodule

// File: doc/count_lead_unit.md
Name: count_lead_unit

Overview:
- Iterative leading-zero / leading-one counter for the multi-cycle MIPS datapath; implements CLZ/CLO.
- The inverse of the barrel shifter: the shifter takes a shift amount and produces a shifted value; this block takes a value and produces the shift amount that normalises it, plus the normalised value.
- Binary-search algorithm, one log2 stage per clock, in the same 16/8/4/2/1 stage order as the shifter.
- Sits beside the ALU and is sequenced by the control FSM with a Start/Done handshake.

Parameters:
- WIDTH, 32, operand width; must be a power of two, at least 4.
- LOGW, 5, log2(WIDTH); also the number of search stages.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- Start  in  1  request; sampled only when in IDLE.
- A  in  WIDTH  operand; captured on the accepting edge.
- CNTOp  in  1  0 = CLZ, 1 = CLO; captured with A.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse; results are valid from this cycle.
- Count  out  LOGW+1  leading-bit count, 0..WIDTH.
- Norm  out  WIDTH  A shifted left by Count, zero fill; 0 when Count = WIDTH.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE;
  - Busy, Done, Count and Norm all go to 0;
  - the in-flight operation is discarded and no Done is produced for it.
- States are IDLE, SCAN, FIN. A stage index k runs 0..LOGW-1.
- IDLE, Start = 1 at edge E0:
  - X <= (CNTOp ? ~A : A), the working search value;
  - S <= A, the shadow value for Norm;
  - Cnt <= 0, k <= 0, Busy <= 1, state <= SCAN.
- SCAN, at each edge with w = WIDTH >> (k+1):
  - if X[WIDTH-1 -: w] == 0, then X <= X << w, S <= S << w, Cnt <= Cnt + w;
  - k <= k + 1;
  - after the stage with k = LOGW-1, state <= FIN.
- FIN, one edge:
  - if X[WIDTH-1] == 0, then Cnt <= Cnt + 1 and S <= 0 (all-zero conditioned operand);
  - Count <= final Cnt, Norm <= final S;
  - Done <= 1, Busy <= 0, state <= IDLE.
- Latency: Start accepted at edge E0, SCAN on edges E1..E(LOGW), FIN on edge E(LOGW+1). Done is high for the cycle after E(LOGW+1), which is 6 edges for WIDTH = 32.
- Done is high for exactly one cycle, then low.
- Count and Norm hold their values until the next FIN or a reset.
- Start while Busy is ignored; no queuing.
- Start in the cycle Done is high is accepted, since the block is already in IDLE. This gives back-to-back operation with no bubble.
- A and CNTOp need only be valid in the accepting cycle; later changes have no effect.
- Width and arithmetic rules:
  - Cnt is LOGW+1 bits wide and never exceeds WIDTH;
  - shifts are logical, zero-filled;
  - for CLO, Norm is derived from the original A, not from ~A.
- Boundary values:
  - A = 0 with CLZ, or A = all-ones with CLO, gives Count = WIDTH and Norm = 0;
  - operand MSB already terminal gives Count = 0 and Norm = A.

Decomposition:
- Shared parameter include, alongside the existing SHTOp codes:
  - CNTOp_CLZ = 1'b0, CNTOp_CLO = 1'b1;
  - state encodings CNT_IDLE, CNT_SCAN, CNT_FIN (2 bits).
- One natural combinational sub-module, clz_stage:
  - inputs X, S, k;
  - outputs next X, next S, increment;
  - the FSM/register wrapper instantiates it once.

Test Plan:
- CLZ, A = 0x00000001 -> Done after 6 edges; Count = 31, Norm = 0x80000000; Busy high for exactly 6 cycles.
- CLZ, A = 0x00000000 -> Count = 32, Norm = 0. Then CLZ, A = 0x80000000 -> Count = 0, Norm = 0x80000000.
- CLO, A = 0xFFFF0F00 -> Count = 16, Norm = 0x0F000000. Then CLO, A = 0xFFFFFFFF -> Count = 32, Norm = 0.
- Start with CLZ A = 0x00F00000, then Start pulsed again with A = 0 at edge E2 while Busy -> second request ignored; Count = 8, Norm = 0xF0000000.
- Start asserted in the Done cycle with A = 0x00010000 -> accepted with no bubble; next Done 6 cycles later, Count = 15.
- rst asserted between clock edges during SCAN -> Busy, Done, Count and Norm go to 0 immediately. After release, no Done appears until a new Start.
